// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (instruction / data) arbiter in front of one shared
//            single-cycle memory. Grant is combinational; simultaneous
//            requests alternate through a priority register so a waiting
//            port is served on the very next cycle. Read data is routed back
//            to the port that issued the read, and held there until that
//            port's next read completes.
// Ports    : clk, nrst                 clock, synchronous active-low reset
//            i_ncs/i_nwe/i_addr/       instruction-port request (active-low)
//            i_wdata/i_wmask
//            i_rdata, i_stall          instruction-port read data / accept
//            d_*                       same set for the data port
//            m_ncs/m_nwe/m_addr/       shared-memory request
//            m_wdata/m_wmask
//            m_rdata                   shared-memory read data (1-cycle)
//            conflict_cnt              saturating count of conflict cycles
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_ncs,
    input  logic                  i_nwe,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_wmask,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_stall,
    input  logic                  d_ncs,
    input  logic                  d_nwe,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [DATA_WIDTH-1:0] d_wmask,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_stall,
    output logic                  m_ncs,
    output logic                  m_nwe,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [DATA_WIDTH-1:0] m_wmask,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic [31:0]           conflict_cnt
);

    localparam logic       c_PRIO_I   = 1'b0;
    localparam logic       c_PRIO_D   = 1'b1;
    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_I    = 2'd1;
    localparam logic [1:0] c_OWN_D    = 2'd2;

    logic                  r_prio;
    logic [1:0]            r_rsp_owner;
    logic [DATA_WIDTH-1:0] r_i_hold;
    logic [DATA_WIDTH-1:0] r_d_hold;
    logic [31:0]           r_conflict_cnt;

    logic        w_i_req;
    logic        w_d_req;
    logic        w_both;
    logic        w_grant_i;
    logic        w_grant_d;
    logic [31:0] w_cnt_next;

    // Requests are masked while reset is held so nothing reaches memory.
    assign w_i_req   = nrst & ~i_ncs;
    assign w_d_req   = nrst & ~d_ncs;
    assign w_both    = w_i_req & w_d_req;
    assign w_grant_i = w_i_req & (~w_d_req | (r_prio == c_PRIO_I));
    assign w_grant_d = w_d_req & (~w_i_req | (r_prio == c_PRIO_D));

    // Stall is an "accepted" strobe: high when granted or idle, low only for
    // a requester that lost arbitration, and low for both during reset.
    assign i_stall = nrst & (w_grant_i | ~w_i_req);
    assign d_stall = nrst & (w_grant_d | ~w_d_req);

    always_comb begin
        m_ncs   = 1'b1;
        m_nwe   = 1'b1;
        m_addr  = '0;
        m_wdata = '0;
        m_wmask = '0;
        if (w_grant_i) begin
            m_ncs   = 1'b0;
            m_nwe   = i_nwe;
            m_addr  = i_addr;
            m_wdata = i_wdata;
            m_wmask = i_wmask;
        end else if (w_grant_d) begin
            m_ncs   = 1'b0;
            m_nwe   = d_nwe;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_wmask = d_wmask;
        end
    end

    // The owning port sees memory data directly in the response cycle, which
    // keeps read latency identical to a direct attachment; afterwards it
    // sees the copy captured at the end of that cycle.
    assign i_rdata = (r_rsp_owner == c_OWN_I) ? m_rdata : r_i_hold;
    assign d_rdata = (r_rsp_owner == c_OWN_D) ? m_rdata : r_d_hold;

    // The counter always reloads (holding value when not counting) so that
    // it never depends on a previous assignment persisting.
    assign w_cnt_next = (w_both && (r_conflict_cnt != 32'hFFFF_FFFF))
                        ? r_conflict_cnt + 32'd1 : r_conflict_cnt;
    assign conflict_cnt = r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_prio         <= c_PRIO_D;
            r_rsp_owner    <= c_OWN_NONE;
            r_i_hold       <= '0;
            r_d_hold       <= '0;
            r_conflict_cnt <= '0;
        end else begin
            // The loser of a conflict gets priority for the next cycle.
            if (w_both) begin
                r_prio <= w_grant_i ? c_PRIO_D : c_PRIO_I;
            end

            if (w_grant_i && i_nwe) begin
                r_rsp_owner <= c_OWN_I;
            end else if (w_grant_d && d_nwe) begin
                r_rsp_owner <= c_OWN_D;
            end else begin
                r_rsp_owner <= c_OWN_NONE;
            end

            if (r_rsp_owner == c_OWN_I) begin
                r_i_hold <= m_rdata;
            end
            if (r_rsp_owner == c_OWN_D) begin
                r_d_hold <= m_rdata;
            end

            r_conflict_cnt <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed vector table,
//            hand-written corner sequences and a randomized run compared
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_AW = 32;
    localparam int c_DW = 64;

    logic            clk = 1'b0;
    logic            nrst;
    logic            i_ncs, i_nwe, d_ncs, d_nwe;
    logic [c_AW-1:0] i_addr, d_addr;
    logic [c_DW-1:0] i_wdata, i_wmask, d_wdata, d_wmask;
    logic [c_DW-1:0] i_rdata, d_rdata;
    logic            i_stall, d_stall;
    logic            m_ncs, m_nwe;
    logic [c_AW-1:0] m_addr;
    logic [c_DW-1:0] m_wdata, m_wmask;
    logic [c_DW-1:0] m_rdata = '0;
    logic [31:0]     conflict_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) dut (
        .clk(clk), .nrst(nrst),
        .i_ncs(i_ncs), .i_nwe(i_nwe), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wmask(i_wmask), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_ncs(d_ncs), .d_nwe(d_nwe), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_rdata(d_rdata), .d_stall(d_stall),
        .m_ncs(m_ncs), .m_nwe(m_nwe), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
    );

    function automatic logic [63:0] mem_init(int i);
        return {32'hC0DE_0000 + 32'(i), 32'h0BAD_0000 + 32'(i)};
    endfunction

    function automatic int widx(logic [c_AW-1:0] a);
        return int'(a[10:3]);
    endfunction

    // Shared memory attached to the m_* side: unwritten words read as mem_init.
    bit        env_written [256];
    logic [63:0] env_mem   [256];
    always @(posedge clk) begin
        if (!m_ncs) begin
            if (!m_nwe) begin
                env_mem[widx(m_addr)] <=
                    ((env_written[widx(m_addr)] ? env_mem[widx(m_addr)] : mem_init(widx(m_addr)))
                     & ~m_wmask) | (m_wdata & m_wmask);
                env_written[widx(m_addr)] <= 1'b1;
            end else begin
                m_rdata <= env_written[widx(m_addr)] ? env_mem[widx(m_addr)]
                                                     : mem_init(widx(m_addr));
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: who wins, what each port last read, conflict tally.
    logic [63:0] ref_mem [256];
    bit          mdl_prio_d;
    logic [31:0] mdl_cnt;
    logic [63:0] mdl_i_rd, mdl_d_rd;
    int          mdl_win;   // 0 none, 1 instruction, 2 data

    task automatic model_reset();
        mdl_prio_d = 1'b1;
        mdl_cnt    = '0;
        mdl_i_rd   = '0;
        mdl_d_rd   = '0;
    endtask

    task automatic model_step();
        bit ri, rd;
        ri = nrst && !i_ncs;
        rd = nrst && !d_ncs;
        mdl_win = (ri && rd) ? (mdl_prio_d ? 2 : 1) : ri ? 1 : rd ? 2 : 0;
        chk("m_ncs", m_ncs, (mdl_win == 0) ? 1 : 0);
        chk("m_nwe", m_nwe, (mdl_win == 1) ? i_nwe : (mdl_win == 2) ? d_nwe : 1'b1);
        chk("m_addr", m_addr, (mdl_win == 1) ? i_addr : (mdl_win == 2) ? d_addr : '0);
        chk("m_wdata", m_wdata, (mdl_win == 1) ? i_wdata : (mdl_win == 2) ? d_wdata : '0);
        chk("m_wmask", m_wmask, (mdl_win == 1) ? i_wmask : (mdl_win == 2) ? d_wmask : '0);
        chk("i_stall", i_stall, nrst && (mdl_win == 1 || !ri));
        chk("d_stall", d_stall, nrst && (mdl_win == 2 || !rd));
        chk("i_rdata", i_rdata, mdl_i_rd);
        chk("d_rdata", d_rdata, mdl_d_rd);
        chk("conflict_cnt", conflict_cnt, mdl_cnt);
        if (!nrst) begin
            model_reset();
        end else begin
            if (ri && rd) begin
                mdl_prio_d = (mdl_win == 1);
                if (mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 1;
            end
            if (mdl_win == 1) begin
                if (i_nwe) mdl_i_rd = ref_mem[widx(i_addr)];
                else ref_mem[widx(i_addr)] = (ref_mem[widx(i_addr)] & ~i_wmask) | (i_wdata & i_wmask);
            end else if (mdl_win == 2) begin
                if (d_nwe) mdl_d_rd = ref_mem[widx(d_addr)];
                else ref_mem[widx(d_addr)] = (ref_mem[widx(d_addr)] & ~d_wmask) | (d_wdata & d_wmask);
            end
        end
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        i_ncs = 1; i_nwe = 1; i_addr = '0; i_wdata = '0; i_wmask = '0;
        d_ncs = 1; d_nwe = 1; d_addr = '0; d_wdata = '0; d_wmask = '0;
    endtask

    typedef struct {
        logic        nrst;
        logic        incs;
        logic [31:0] iaddr;
        logic        dncs;
        logic [31:0] daddr;
        logic        e_mncs;
        logic [31:0] e_maddr;
        logic        e_istall;
        logic        e_dstall;
        logic [31:0] e_cnt;
        logic [63:0] e_irdata;
        logic [63:0] e_drdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        bit i_wait, d_wait;
        for (int k = 0; k < 256; k++) ref_mem[k] = mem_init(k);
        model_reset();
        mdl_win = 0;
        nrst = 0;
        set_idle();

        //          nrst incs iaddr   dncs daddr  mncs maddr   ist dst cnt  irdata        drdata
        vecs[0] = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h0,   1'b0, 1'b0, 0, 64'h0,          64'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0,   1'b1, 32'h0, 1'b1, 32'h0,   1'b0, 1'b0, 0, 64'h0,          64'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 1'b1, 32'h0, 1'b0, 32'h100, 1'b1, 1'b1, 0, 64'h0,          64'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h0,   1'b1, 32'h0, 1'b1, 32'h0,   1'b1, 1'b1, 0, mem_init(32),   64'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h8, 1'b0, 32'h8,   1'b0, 1'b1, 0, mem_init(32),   64'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h10,1'b0, 32'h0,   1'b1, 1'b0, 1, mem_init(32),   mem_init(1)};
        vecs[6] = '{1'b1, 1'b0, 32'h18,  1'b0, 32'h10,1'b0, 32'h10,  1'b0, 1'b1, 2, mem_init(0),    mem_init(1)};
        vecs[7] = '{1'b1, 1'b0, 32'h18,  1'b0, 32'h20,1'b0, 32'h18,  1'b1, 1'b0, 3, mem_init(0),    mem_init(2)};
        vecs[8] = '{1'b1, 1'b1, 32'h0,   1'b1, 32'h0, 1'b1, 32'h0,   1'b1, 1'b1, 4, mem_init(3),    mem_init(2)};

        @(posedge clk);
        #1;
        for (int v = 0; v < 9; v++) begin
            nrst = vecs[v].nrst;
            i_ncs = vecs[v].incs; i_nwe = 1; i_addr = vecs[v].iaddr;
            d_ncs = vecs[v].dncs; d_nwe = 1; d_addr = vecs[v].daddr;
            to_sample();
            chk($sformatf("vec%0d_m_ncs", v), m_ncs, vecs[v].e_mncs);
            chk($sformatf("vec%0d_m_addr", v), m_addr, vecs[v].e_maddr);
            chk($sformatf("vec%0d_i_stall", v), i_stall, vecs[v].e_istall);
            chk($sformatf("vec%0d_d_stall", v), d_stall, vecs[v].e_dstall);
            chk($sformatf("vec%0d_cnt", v), conflict_cnt, vecs[v].e_cnt);
            chk($sformatf("vec%0d_i_rdata", v), i_rdata, vecs[v].e_irdata);
            chk($sformatf("vec%0d_d_rdata", v), d_rdata, vecs[v].e_drdata);
            finish_cycle();
        end

        // Data-port write then instruction-port read of the same word.
        set_idle();
        d_ncs = 0; d_nwe = 0; d_addr = 32'h40; d_wdata = 64'hDEAD_BEEF; d_wmask = '1;
        to_sample();
        finish_cycle();
        set_idle();
        i_ncs = 0; i_addr = 32'h40;
        to_sample();
        finish_cycle();
        set_idle();
        to_sample();
        chk("wr_rd_i_rdata", i_rdata, 64'h0000_0000_DEAD_BEEF);
        chk("wr_rd_d_rdata_kept", d_rdata, mem_init(2));
        finish_cycle();

        // Reset arriving while a data read is in flight.
        d_ncs = 0; d_addr = 32'h48;
        to_sample();
        chk("pend_d_stall", d_stall, 1'b1);
        finish_cycle();
        nrst = 0;
        to_sample();
        chk("rst_m_ncs", m_ncs, 1'b1);
        chk("rst_i_stall", i_stall, 1'b0);
        chk("rst_d_stall", d_stall, 1'b0);
        finish_cycle();
        nrst = 1;
        set_idle();
        to_sample();
        chk("post_rst_d_rdata", d_rdata, 64'h0);
        finish_cycle();
        i_ncs = 0; i_addr = 32'h0; d_ncs = 0; d_addr = 32'h8;
        to_sample();
        chk("post_rst_grant_d", m_addr, 32'h8);
        chk("post_rst_i_stall", i_stall, 1'b0);
        finish_cycle();
        set_idle();
        to_sample();
        finish_cycle();

        // Randomized traffic; a losing requester keeps its request.
        i_wait = 0;
        d_wait = 0;
        for (int n = 0; n < 400; n++) begin
            nrst = ($urandom_range(0, 39) != 0);
            if (!i_wait) begin
                i_ncs = ($urandom_range(0, 2) == 0);
                i_nwe = $urandom_range(0, 3) != 0;
                i_addr = {$urandom_range(0, 15), 3'b000};
                i_wdata = {$urandom, $urandom};
                i_wmask = {$urandom, $urandom};
            end
            if (!d_wait) begin
                d_ncs = ($urandom_range(0, 2) == 0);
                d_nwe = $urandom_range(0, 1) != 0;
                d_addr = {$urandom_range(0, 15), 3'b000};
                d_wdata = {$urandom, $urandom};
                d_wmask = {$urandom, $urandom};
            end
            to_sample();
            if (i_wait && nrst) chk("max_wait_i", i_stall, 1'b1);
            if (d_wait && nrst) chk("max_wait_d", d_stall, 1'b1);
            finish_cycle();
            i_wait = nrst && !i_ncs && (mdl_win != 1);
            d_wait = nrst && !d_ncs && (mdl_win != 2);
        end

        // Counter saturation: preload near the top, then three conflicts.
        nrst = 1;
        set_idle();
        force dut.r_conflict_cnt = 32'hFFFF_FFFE;
        mdl_cnt = 32'hFFFF_FFFE;
        to_sample();
        finish_cycle();
        release dut.r_conflict_cnt;
        for (int c = 0; c < 3; c++) begin
            i_ncs = 0; i_nwe = 1; i_addr = 32'h10;
            d_ncs = 0; d_nwe = 1; d_addr = 32'h18;
            to_sample();
            finish_cycle();
        end
        set_idle();
        to_sample();
        chk("cnt_saturated", conflict_cnt, 32'hFFFF_FFFF);
        finish_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
